// File: rtl/sprite_line_selector.sv
// Double-buffered scanline sprite evaluator. On each accepted start it walks
// OAM once, collects the first MAX_PER_LINE enabled objects covering the
// target line into the back bank, then swaps banks so the renderer always
// reads a stable front bank.
module sprite_line_selector #(
  parameter int OAM_OBJECTS  = 64,
  parameter int OAM_ADDR_W   = 6,
  parameter int MAX_PER_LINE = 32,
  parameter int SLOT_W       = 5,
  parameter int SPRITE_H     = 16,
  parameter int ROW_W        = 4,
  parameter int Y_W          = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [Y_W-1:0]                target_y,
  output logic [OAM_ADDR_W-1:0]         oam_addr,
  input  logic [31:0]                   oam_data,
  output logic                          busy,
  output logic                          done,
  input  logic [SLOT_W-1:0]             rd_slot,
  output logic [OAM_ADDR_W+ROW_W:0]     rd_entry,
  output logic [SLOT_W:0]               count,
  output logic                          overflow
);

  localparam logic [OAM_ADDR_W-1:0] LAST_ADDR = OAM_ADDR_W'(OAM_OBJECTS - 1);
  localparam logic [SLOT_W:0]       CAP       = (SLOT_W + 1)'(MAX_PER_LINE);

  typedef enum logic [1:0] {IDLE, SCAN, SWAP} state_t;

  state_t                  state, state_nxt;
  logic                    accept, wr_en, ovf_hit, last_eval;
  logic                    issue_act;
  logic                    done_r;
  logic                    bank_sel;
  logic                    back;

  logic [Y_W-1:0]          target_y_p0;
  logic                    vld_p1;
  logic [OAM_ADDR_W-1:0]   idx_p1;
  logic signed [Y_W:0]     diff_p1;
  logic                    hit_p1;
  logic [ROW_W-1:0]        row_p1;

  logic [MAX_PER_LINE-1:0] slot_vld [2];
  logic [OAM_ADDR_W-1:0]   slot_idx [2][MAX_PER_LINE];
  logic [ROW_W-1:0]        slot_row [2][MAX_PER_LINE];
  logic [SLOT_W:0]         bank_cnt [2];
  logic                    bank_ovf [2];

  logic                    unused_fields;

  // Distance of the target line below the sprite top; negative when above.
  function automatic logic signed [Y_W:0] line_diff(input logic [Y_W-1:0] ty,
                                                     input logic [Y_W-1:0] yp);
    return signed'({1'b0, ty}) - signed'({1'b0, yp});
  endfunction

  // No vertical wrap: a negative distance is never a hit.
  function automatic logic hit_test(input logic en, input logic signed [Y_W:0] d);
    return en && !d[Y_W] && (d[Y_W-1:0] < Y_W'(SPRITE_H));
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input logic flip, input logic [ROW_W-1:0] d);
    return flip ? (ROW_W'(SPRITE_H - 1) - d) : d;
  endfunction

  assign back          = ~bank_sel;
  assign unused_fields = ^{oam_data[29:28], oam_data[17:0]};

  // stage p1: OAM word for idx_p1 arrives from the synchronous RAM
  assign diff_p1   = line_diff(target_y_p0, Y_W'(oam_data[27:18]));
  assign hit_p1    = vld_p1 && hit_test(oam_data[31], diff_p1);
  assign row_p1    = row_of(oam_data[30], diff_p1[ROW_W-1:0]);
  assign last_eval = vld_p1 && (idx_p1 == LAST_ADDR);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state: a full list ends the scan early
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (ovf_hit || last_eval) state_nxt = SWAP;
      SWAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs and per-cycle strobes
  always_comb begin
    busy    = (state != IDLE);
    accept  = (state == IDLE) && start;
    wr_en   = (state == SCAN) && hit_p1 && (bank_cnt[back] < CAP);
    ovf_hit = (state == SCAN) && hit_p1 && (bank_cnt[back] >= CAP);
  end

  // Scan control, bank bookkeeping and the bank swap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oam_addr  <= '0;
      issue_act <= 1'b0;
      vld_p1    <= 1'b0;
      done_r    <= 1'b0;
      bank_sel  <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        slot_vld[b] <= '0;
        bank_cnt[b] <= '0;
        bank_ovf[b] <= 1'b0;
      end
    end else begin
      done_r <= (state == SWAP);
      if (state == SWAP) bank_sel <= ~bank_sel;

      if (accept) begin
        oam_addr       <= '0;
        issue_act      <= 1'b1;
        vld_p1         <= 1'b0;
        slot_vld[back] <= '0;
        bank_cnt[back] <= '0;
        bank_ovf[back] <= 1'b0;
      end else if (state == SCAN) begin
        vld_p1 <= issue_act;
        if (issue_act) begin
          if (oam_addr == LAST_ADDR) issue_act <= 1'b0;
          else                       oam_addr  <= oam_addr + 1'b1;
        end
        if (wr_en) begin
          slot_vld[back][bank_cnt[back][SLOT_W-1:0]] <= 1'b1;
          bank_cnt[back] <= bank_cnt[back] + 1'b1;
        end
        if (ovf_hit) bank_ovf[back] <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  // Datapath registers: latched target line, index pipe, slot payloads
  always_ff @(posedge clk) begin
    if (accept) target_y_p0 <= target_y;
    idx_p1 <= oam_addr;
    if (wr_en) begin
      slot_idx[back][bank_cnt[back][SLOT_W-1:0]] <= idx_p1;
      slot_row[back][bank_cnt[back][SLOT_W-1:0]] <= row_p1;
    end
  end

  assign done     = done_r;
  assign count    = bank_cnt[bank_sel];
  assign overflow = bank_ovf[bank_sel];

  // Front-bank read port; empty or out-of-range slots read as all zeros
  always_comb begin
    rd_entry = '0;
    if (({1'b0, rd_slot} < CAP) && slot_vld[bank_sel][rd_slot])
      rd_entry = {1'b1, slot_idx[bank_sel][rd_slot], slot_row[bank_sel][rd_slot]};
  end

endmodule

// File: tb/tb_sprite_line_selector.sv
// Bench for sprite_line_selector: synchronous OAM model, list reference
// model computed directly from the selection rules, directed and random lines.
module tb_sprite_line_selector;

  localparam int OBJ  = 64;
  localparam int MAXL = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  target_y;
  logic [5:0]  oam_addr;
  logic [31:0] oam_data;
  logic        busy;
  logic        done;
  logic [4:0]  rd_slot;
  logic [10:0] rd_entry;
  logic [5:0]  count;
  logic        overflow;

  logic [31:0] oam_mem [OBJ];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e0_cyc = 0;

  int exp_n, exp_done_cyc;
  bit exp_ovf;
  int exp_idx [MAXL];
  int exp_row [MAXL];
  int f_n = 0;
  bit f_ovf = 0;
  int f_idx [MAXL];
  int f_row [MAXL];

  sprite_line_selector dut (
    .clk(clk), .reset(reset), .start(start), .target_y(target_y),
    .oam_addr(oam_addr), .oam_data(oam_data), .busy(busy), .done(done),
    .rd_slot(rd_slot), .rd_entry(rd_entry), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) oam_data <= oam_mem[oam_addr];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obj(input bit en, input bit flip, input int yp, input logic [17:0] low);
    return {en, flip, 2'b00, 10'(yp), low};
  endfunction

  task automatic clear_oam();
    for (int i = 0; i < OBJ; i++) oam_mem[i] = {1'b0, 31'($urandom)};
  endtask

  // Reference: walk objects in order, keep hits until the list is full.
  task automatic model(input int ty);
    exp_n = 0; exp_ovf = 0; exp_done_cyc = OBJ + 2;
    for (int i = 0; i < OBJ; i++) begin
      int yp, d;
      if (!oam_mem[i][31]) continue;
      yp = int'(oam_mem[i][27:18]);
      d  = ty - yp;
      if (d < 0 || d >= 16) continue;
      if (exp_n == MAXL) begin
        exp_ovf = 1; exp_done_cyc = i + 3;
        break;
      end
      exp_idx[exp_n] = i;
      exp_row[exp_n] = oam_mem[i][30] ? 15 - d : d;
      exp_n++;
    end
  endtask

  function automatic logic [10:0] f_entry(input int s);
    logic [31:0] ix, rw;
    if (s >= f_n) return 11'd0;
    ix = f_idx[s]; rw = f_row[s];
    return {1'b1, ix[5:0], rw[3:0]};
  endfunction

  // Caller sits 1 time unit after an edge with the DUT idle.
  task automatic pulse_start(input string tag, input int ty);
    model(ty);
    target_y = 10'(ty);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e0_cyc = cyc;
    target_y = 10'($urandom);
    chk({tag, "_busy_on_accept"}, busy, 1);
  endtask

  task automatic wait_done(input string tag, input bit mid);
    int c;
    bit addr_ok, busy_ok, mid_done;
    addr_ok = 1; busy_ok = 1; mid_done = 0;
    c = cyc - e0_cyc;
    while (done !== 1'b1 && c < 200) begin
      if (busy !== 1'b1) busy_ok = 0;
      if (c < OBJ && c <= exp_done_cyc - 2 && oam_addr !== c[5:0]) addr_ok = 0;
      if (mid && !mid_done && c >= 20) begin
        chk({tag, "_mid_count"}, count, f_n);
        chk({tag, "_mid_ovf"}, overflow, f_ovf);
        for (int s = 0; s < 3; s++) begin
          rd_slot = 5'(s); #1;
          chk($sformatf("%s_mid_slot%0d", tag, s), rd_entry, f_entry(s));
        end
        start = 1'b1;
        target_y = 10'd777;
        mid_done = 1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      c = cyc - e0_cyc;
    end
    chk({tag, "_done_cycle"}, c, exp_done_cyc);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_addr_seq"}, addr_ok, 1);
    chk({tag, "_busy_during"}, busy_ok, 1);
    f_n = exp_n; f_ovf = exp_ovf;
    for (int s = 0; s < MAXL; s++) begin
      f_idx[s] = exp_idx[s]; f_row[s] = exp_row[s];
    end
  endtask

  task automatic check_front(input string tag);
    chk({tag, "_count"}, count, f_n);
    chk({tag, "_overflow"}, overflow, f_ovf);
    for (int s = 0; s < MAXL; s++) begin
      rd_slot = 5'(s); #1;
      chk($sformatf("%s_slot%0d", tag, s), rd_entry, f_entry(s));
    end
  endtask

  initial begin
    int bty [5];
    bit quiet;
    reset = 1'b1; start = 1'b0; target_y = '0; rd_slot = '0;
    clear_oam();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", oam_addr, 0);
    check_front("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // Two hits, one y-flipped, plus a disabled object on the same line
    clear_oam();
    oam_mem[3] = obj(1, 0, 100, 18'h1234);
    oam_mem[7] = obj(1, 1, 110, 18'h0055);
    oam_mem[9] = obj(0, 0, 100, 18'h0aaa);
    pulse_start("basic", 112);
    wait_done("basic", 0);
    check_front("basic");
    chk("basic_slot0_direct", f_entry(0), {1'b1, 6'd3, 4'd12});
    chk("basic_slot1_direct", f_entry(1), {1'b1, 6'd7, 4'd13});

    // List overflow: 40 hits on one line
    clear_oam();
    for (int i = 0; i < 40; i++) oam_mem[i] = obj(1, 0, 50, 18'($urandom));
    pulse_start("ovf", 50);
    wait_done("ovf", 0);
    check_front("ovf");

    // Vertical boundaries and no wrap; each start lands in the done cycle
    clear_oam();
    oam_mem[0] = obj(1, 0, 200, 18'h0);
    oam_mem[1] = obj(1, 0, 1020, 18'h0);
    bty = '{199, 200, 215, 216, 3};
    pulse_start("bnd0", bty[0]);
    for (int j = 0; j < 5; j++) begin
      wait_done($sformatf("bnd%0d", j), 0);
      if (j < 4) pulse_start($sformatf("bnd%0d", j + 1), bty[j + 1]);
      check_front($sformatf("bnd%0d", j));
    end
    @(posedge clk); #1;

    // Double buffering: line A stays visible while line B is prepared
    clear_oam();
    oam_mem[3] = obj(1, 0, 100, 18'h0);
    oam_mem[7] = obj(1, 1, 110, 18'h0);
    pulse_start("dbA", 112);
    wait_done("dbA", 0);
    check_front("dbA");
    clear_oam();
    oam_mem[2]  = obj(1, 0, 300, 18'h0);
    oam_mem[10] = obj(1, 1, 295, 18'h0);
    oam_mem[20] = obj(1, 0, 290, 18'h0);
    oam_mem[30] = obj(1, 1, 305, 18'h0);
    oam_mem[63] = obj(1, 0, 302, 18'h0);
    pulse_start("dbB", 305);
    wait_done("dbB", 1);
    check_front("dbB");

    // Random lines
    for (int r = 0; r < 6; r++) begin
      int ty, pct;
      ty  = (r == 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 1023));
      pct = int'($urandom_range(15, 85));
      for (int i = 0; i < OBJ; i++)
        oam_mem[i] = obj(int'($urandom_range(0, 99)) < pct, 1'($urandom),
                         (ty + 1024 - int'($urandom_range(0, 20))) % 1024, 18'($urandom));
      pulse_start($sformatf("rnd%0d", r), ty);
      wait_done($sformatf("rnd%0d", r), 0);
      check_front($sformatf("rnd%0d", r));
    end

    // Reset in the middle of a scan abandons it and clears both banks
    clear_oam();
    oam_mem[3] = obj(1, 0, 100, 18'h0);
    oam_mem[7] = obj(1, 1, 110, 18'h0);
    pulse_start("rmid", 112);
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rmid_busy", busy, 0);
    chk("rmid_done", done, 0);
    chk("rmid_addr", oam_addr, 0);
    #1;
    reset = 1'b0;
    f_n = 0; f_ovf = 0;
    check_front("rmid");
    quiet = 1;
    for (int k = 0; k < 70; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) quiet = 0;
    end
    chk("rmid_no_swap", quiet, 1);
    pulse_start("rpost", 112);
    wait_done("rpost", 0);
    check_front("rpost");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
